charbuf_scroll_ram: RTL
=======================

// Module: charbuf_scroll_ram
// PURPOSE
//  Parametrised character/attribute text buffer for the VGA text pipeline, on inferred single-clock block RAM.
//  Each word holds the glyph code in [7:0] and the attribute/colour in [DW-1:8].
//  The host writes and the video side reads, both by (col,row) logical coordinates.
//  Adds what the fixed-size buffer lacks: a hardware fill/clear engine and hardware scroll via a wrapping top-row offset.
// PARAMETERS
//  COLS_LOG2   6        log2 of columns (64)
//  ROWS_LOG2   5        log2 of rows (32)
//  DW          16       word width; [7:0] char, [DW-1:8] attribute; DW>=9
// PORTS
//  clk         in   1          single clock for all logic and RAM
//  reset       in   1          synchronous, active-high
//  wr_en       in   1          host write strobe
//  wr_col      in   COLS_LOG2  host write column
//  wr_row      in   ROWS_LOG2  host write logical row
//  wr_data     in   DW         host write word
//  rd_en       in   1          video read strobe
//  rd_col      in   COLS_LOG2  video read column
//  rd_row      in   ROWS_LOG2  video read logical row
//  rd_data     out  DW         read word, valid when rd_valid=1
//  rd_valid    out  1          rd_en delayed 2 cycles
//  fill_req    in   1          pulse: overwrite whole buffer with fill_value
//  scroll_req  in   1          pulse: scroll up one line, new bottom line := fill_value
//  fill_value  in   DW         word used by fill and scroll; latched when a request is accepted
//  busy        out  1          engine active; requests and host writes ignored
//  top_row     out  ROWS_LOG2  physical row currently shown as logical row 0
// BEHAVIOUR
//  - Address mapping: phys_row = (row + top_row) mod 2^ROWS_LOG2 (natural wrap); addr = {phys_row, col}.
//  - Read latency is 2 cycles: address register, then output register.
//    - rd_data/rd_valid update every cycle; rd_valid follows rd_en exactly 2 cycles later.
//    - Reads are always served, including while busy.
//  - Host write takes effect in the issuing cycle's RAM write. Write and read to the same address in one cycle returns OLD data.
//  - Reset: rd_data=0, rd_valid=0, busy=0, top_row=0, FSM=IDLE. RAM contents are not cleared.
//  - FSM states IDLE, FILL, SCROLL. One engine RAM write per cycle; engine owns the write port while busy.
//    - IDLE: fill_req -> FILL (top_row:=0, counter:=0, latch fill_value). Otherwise scroll_req -> SCROLL (counter:=0, latch fill_value).
//      fill_req wins if both requests arrive in the same cycle. busy rises the cycle after acceptance.
//    - FILL: writes physical addr=counter for 2^(COLS_LOG2+ROWS_LOG2) cycles, then returns to IDLE.
//    - SCROLL: writes physical row top_row, cols 0..COLS-1 (COLS cycles).
//      In the last cycle, top_row:=top_row+1 (wraps ROWS-1 -> 0), then returns to IDLE.
//    - busy=1 exactly while in FILL or SCROLL.
//  - While busy, wr_en, fill_req and scroll_req are dropped, not queued.
//  - Reset mid-operation aborts the engine: RAM is left partially written, top_row=0.
// CONFIGURATION
//  CHARBUF_CURSOR_EN defined: adds a teletype write cursor.
//    - Ports: cur_we in 1, cur_data in DW, cur_col out COLS_LOG2, cur_row out ROWS_LOG2 (logical).
//    - Cursor position resets to (0,0).
//    - cur_we writes cur_data at the cursor position, then col+1.
//    - Past the last column: col:=0, row+1.
//    - Past the last column of the last row: col:=0, row stays ROWS-1, and an internal scroll_req is issued.
//    - cur_we is dropped while busy. It has priority over wr_en in the same cycle.
//    - A completed fill returns the cursor to (0,0).
//  CHARBUF_CURSOR_EN undefined: cursor ports and logic are absent; behaviour is exactly as above.
// TESTING (defaults 64x32, DW=16)
//  1. Write (5,3)=16'h1E41, rd_en at (5,3) -> rd_valid=1 and rd_data=16'h1E41 exactly 2 cycles later.
//  2. fill_req, fill_value=16'h0720 -> busy for 2048 cycles; every read returns 16'h0720; top_row=0.
//  3. Write row0 col0=16'hAAAA, row1 col0=16'hBBBB, scroll_req fill 16'h0000 -> busy 64 cycles; top_row=1;
//     (0,0) reads 16'hBBBB; (0,31) reads 16'h0000.
//  4. 32 scroll_reqs back-to-back (each after busy falls) -> top_row wraps 31->0.
//     wr_en during busy leaves the RAM unchanged.
//  5. fill_req and scroll_req in the same cycle -> FILL runs, 2048 busy cycles.
//     Reset at cycle 100 of the fill -> busy=0, top_row=0, rd_valid=0 next cycle.
//  6. [CURSOR_EN] cursor at (63,31), cur_we data 16'h0741 -> (63,31)=16'h0741; cursor (0,31); scroll runs; top_row+1.

Source files
------------

// File: rtl/charbuf_scroll_ram.sv
// Character/attribute text buffer on single-clock block RAM, with a hardware fill engine and a wrapping top-row scroll.
// Optional teletype write cursor is enabled by defining CHARBUF_CURSOR_EN.
module charbuf_scroll_ram #(
  parameter int unsigned COLS_LOG2 = 6,
  parameter int unsigned ROWS_LOG2 = 5,
  parameter int unsigned DW        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [COLS_LOG2-1:0] wr_col,
  input  logic [ROWS_LOG2-1:0] wr_row,
  input  logic [DW-1:0]        wr_data,
  input  logic                 rd_en,
  input  logic [COLS_LOG2-1:0] rd_col,
  input  logic [ROWS_LOG2-1:0] rd_row,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid,
  input  logic                 fill_req,
  input  logic                 scroll_req,
  input  logic [DW-1:0]        fill_value,
  output logic                 busy,
`ifdef CHARBUF_CURSOR_EN
  input  logic                 cur_we,
  input  logic [DW-1:0]        cur_data,
  output logic [COLS_LOG2-1:0] cur_col,
  output logic [ROWS_LOG2-1:0] cur_row,
`endif
  output logic [ROWS_LOG2-1:0] top_row
);

  localparam int unsigned AW    = COLS_LOG2 + ROWS_LOG2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW-1:0]        LAST_ADDR = '1;
  localparam logic [COLS_LOG2-1:0] LAST_COL  = '1;
`ifdef CHARBUF_CURSOR_EN
  localparam logic [ROWS_LOG2-1:0] LAST_ROW  = '1;
`endif

  typedef enum logic [1:0] {IDLE, FILL, SCROLL} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [DW-1:0]   fill_q;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_addr_q;
  logic            rd_en_q;

  logic            host_we_c;
  logic [AW-1:0]   host_addr_c;
  logic [DW-1:0]   host_data_c;
  logic            scroll_c;
  logic            we_c;
  logic [AW-1:0]   waddr_c;
  logic [DW-1:0]   wdata_c;
`ifdef CHARBUF_CURSOR_EN
  logic            cur_wrap_c;
`endif

  // Write-port arbitration: engine owns the port while busy; cursor beats host in IDLE.
  always_comb begin
    host_we_c   = 1'b0;
    host_addr_c = {ROWS_LOG2'(wr_row + top_row), wr_col};
    host_data_c = wr_data;
    scroll_c    = scroll_req;
`ifdef CHARBUF_CURSOR_EN
    cur_wrap_c  = 1'b0;
    if (cur_we) begin
      host_we_c   = 1'b1;
      host_addr_c = {ROWS_LOG2'(cur_row + top_row), cur_col};
      host_data_c = cur_data;
      cur_wrap_c  = (cur_col == LAST_COL) && (cur_row == LAST_ROW);
    end else begin
      host_we_c = wr_en;
    end
    scroll_c = scroll_req | cur_wrap_c;
`else
    host_we_c = wr_en;
`endif
    we_c    = 1'b0;
    waddr_c = host_addr_c;
    wdata_c = host_data_c;
    case (state)
      IDLE:   we_c = host_we_c;
      FILL: begin
        we_c    = 1'b1;
        waddr_c = cnt;
        wdata_c = fill_q;
      end
      SCROLL: begin
        we_c    = 1'b1;
        waddr_c = {top_row, cnt[COLS_LOG2-1:0]};
        wdata_c = fill_q;
      end
      default: we_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= wdata_c;
  end

  // Two-stage read: logical-to-physical address register, then RAM output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_addr_q <= {ROWS_LOG2'(rd_row + top_row), rd_col};
      rd_en_q   <= rd_en;
      rd_data   <= mem[rd_addr_q];
      rd_valid  <= rd_en_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      top_row <= '0;
      cnt     <= '0;
      fill_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_req) begin
            state   <= FILL;
            busy    <= 1'b1;
            top_row <= '0;
            cnt     <= '0;
            fill_q  <= fill_value;
          end else if (scroll_c) begin
            state  <= SCROLL;
            busy   <= 1'b1;
            cnt    <= '0;
            fill_q <= fill_value;
          end
        end
        FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SCROLL: begin
          cnt <= cnt + 1'b1;
          if (cnt[COLS_LOG2-1:0] == LAST_COL) begin
            top_row <= top_row + 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHARBUF_CURSOR_EN
  // Teletype cursor: advance per accepted write; bottom-right wrap triggers a scroll.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (state == FILL && cnt == LAST_ADDR) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (state == IDLE && cur_we) begin
      if (cur_col == LAST_COL) begin
        cur_col <= '0;
        if (cur_row != LAST_ROW) cur_row <= cur_row + 1'b1;
      end else begin
        cur_col <= cur_col + 1'b1;
      end
    end
  end
`endif

endmodule
